// File: rtl/sort_pkg.sv
// Shared definitions for the sorter result path: default matrix geometry,
// unloader state encoding and the element packing helper.
package sort_pkg;

  localparam int SORT_WIDTH = 8;
  localparam int SORT_ROW   = 8;
  localparam int SORT_COL   = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Bit offset of element (i,j) inside the flattened matrix bus.
  function automatic int elem_lsb(input int i, input int j,
                                  input int cols = SORT_COL,
                                  input int width = SORT_WIDTH);
    return (i * cols + j) * width;
  endfunction

endpackage

// File: rtl/sort_unloader_if.sv
// Matrix-in / serial-stream-out bundle of the sort unloader.
// master = the unloader itself, slave = sorter plus downstream consumer.
interface sort_unloader_if
  import sort_pkg::*;
#(
    parameter int WIDTH = SORT_WIDTH,
    parameter int ROW   = SORT_ROW,
    parameter int COL   = SORT_COL
) ();

    logic                     done;
    logic [WIDTH*ROW*COL-1:0] values;
    logic [WIDTH-1:0]         out_data;
    logic [$clog2(ROW)-1:0]   out_row;
    logic [$clog2(COL)-1:0]   out_col;
    logic                     out_valid;
    logic                     out_last;
    logic                     out_ready;
    logic                     busy;
    logic                     overrun;

    modport master (
        input  done, values, out_ready,
        output out_data, out_row, out_col, out_valid, out_last, busy, overrun
    );

    modport slave (
        output done, values, out_ready,
        input  out_data, out_row, out_col, out_valid, out_last, busy, overrun
    );

endinterface

// File: rtl/sort_unloader_snake_counter.sv
// Row/column walker over a ROW x COL matrix, row-major or boustrophedon.
// Holds at the final element; clr restarts at (0,0) and wins over adv.
module snake_counter #(
    parameter int ROW   = 8,
    parameter int COL   = 8,
    parameter int SNAKE = 1,
    localparam int RW   = $clog2(ROW),
    localparam int CW   = $clog2(COL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    localparam logic [RW-1:0] ROW_MAX  = RW'(ROW - 1);
    localparam logic [CW-1:0] COL_MAX  = CW'(COL - 1);
    // In snake mode an even ROW makes the final row odd, so it ends at column 0.
    localparam logic [CW-1:0] LAST_COL = (SNAKE != 0 && (ROW % 2) == 0) ? '0 : COL_MAX;

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          rev;
    logic          at_end;

    assign rev    = (SNAKE != 0) && row_q[0];
    assign at_end = rev ? (col_q == '0) : (col_q == COL_MAX);
    assign last   = (row_q == ROW_MAX) && (col_q == LAST_COL);

    always_comb begin
        // NOTE: defaults first so no path leaves row_d/col_d unassigned (no latch).
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (adv && !last) begin
            if (at_end) begin
                row_d = row_q + 1'b1;
                if (SNAKE == 0) col_d = '0;
            end else begin
                col_d = rev ? col_q - 1'b1 : col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments; reset is synchronous, active-low.
        if (!rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row = row_q;
    assign col = col_q;

endmodule

// File: rtl/sort_unloader.sv
// Snapshots the sorter's matrix on a rising done and streams it out one
// element per valid/ready handshake, tagged with row and column.
module sort_unloader
  import sort_pkg::*;
#(
    parameter int WIDTH = SORT_WIDTH,
    parameter int ROW   = SORT_ROW,
    parameter int COL   = SORT_COL,
    parameter int SNAKE = 1
) (
    input  logic           clk,
    input  logic           rst,
    sort_unloader_if.master bus
);

    localparam int N  = ROW * COL;
    localparam int RW = $clog2(ROW);
    localparam int CW = $clog2(COL);
    localparam int IW = $clog2(N);

    state_e           state_q, state_d;
    logic             done_q;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] snap_q [N];
    logic [WIDTH-1:0] snap_d [N];

    logic          stream, rise, hs, final_hs, capture, cnt_last;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [IW-1:0] idx;

    snake_counter #(.ROW(ROW), .COL(COL), .SNAKE(SNAKE)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (capture),
        .adv  (hs),
        .row  (row),
        .col  (col),
        .last (cnt_last)
    );

    assign stream   = (state_q == STREAM);
    assign rise     = bus.done & ~done_q;
    assign hs       = stream & bus.out_ready;
    assign final_hs = hs & cnt_last;
    // A new frame may start only from IDLE or on the very handshake that ends the current one.
    assign capture  = rise & (~stream | final_hs);

    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q | (rise & ~capture);
        snap_d    = snap_q;
        if (capture) begin
            state_d = STREAM;
            for (int i = 0; i < ROW; i++)
                for (int j = 0; j < COL; j++)
                    snap_d[i*COL+j] = bus.values[elem_lsb(i, j, COL, WIDTH) +: WIDTH];
        end else if (final_hs) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= bus.done;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: the snapshot is a plain storage array with no reset; it is only
    // read while streaming, after a capture has filled it.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    assign idx = IW'(int'(row) * COL + int'(col));

    assign bus.out_valid = stream;
    assign bus.busy      = stream;
    assign bus.out_last  = stream & cnt_last;
    assign bus.out_data  = stream ? snap_q[idx] : '0;
    assign bus.out_row   = stream ? row : '0;
    assign bus.out_col   = stream ? col : '0;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_sort_unloader.sv
// Two unloaders (snake and row-major) against a frame-list model: each
// capture queues the full expected element sequence, each handshake pops one.
module tb_sort_unloader;
    import sort_pkg::*;

    typedef struct {
        logic [7:0] data;
        int         row;
        int         col;
        bit         last;
    } elem_t;

    logic        clk;
    logic        rst;
    logic        done_s [2];
    logic        rdy    [2];
    logic [511:0] values;

    logic [7:0] o_data  [2];
    logic [2:0] o_row   [2];
    logic [2:0] o_col   [2];
    logic       o_valid [2];
    logic       o_last  [2];
    logic       o_busy  [2];
    logic       o_ovr   [2];

    int n_checks = 0;
    int n_fail   = 0;

    elem_t mframe [2][64];
    int    mpos   [2];
    bit    mact   [2];
    bit    mprev  [2];
    bit    movr   [2];
    elem_t logv   [2][256];
    int    log_n  [2];

    sort_unloader_if bus0 ();
    sort_unloader_if bus1 ();

    sort_unloader #(.WIDTH(8), .ROW(8), .COL(8), .SNAKE(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    sort_unloader #(.WIDTH(8), .ROW(8), .COL(8), .SNAKE(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    assign bus0.done = done_s[0];
    assign bus1.done = done_s[1];
    assign bus0.out_ready = rdy[0];
    assign bus1.out_ready = rdy[1];
    assign bus0.values = values;
    assign bus1.values = values;

    assign o_data[0] = bus0.out_data;   assign o_data[1] = bus1.out_data;
    assign o_row[0]  = bus0.out_row;    assign o_row[1]  = bus1.out_row;
    assign o_col[0]  = bus0.out_col;    assign o_col[1]  = bus1.out_col;
    assign o_valid[0] = bus0.out_valid; assign o_valid[1] = bus1.out_valid;
    assign o_last[0] = bus0.out_last;   assign o_last[1] = bus1.out_last;
    assign o_busy[0] = bus0.busy;       assign o_busy[1] = bus1.busy;
    assign o_ovr[0]  = bus0.overrun;    assign o_ovr[1]  = bus1.overrun;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] elem_of(input int i, input int j);
        return values[elem_lsb(i, j) +: 8];
    endfunction

    // Model: a capture lists the frame in emission order; k=0 is the snake unit.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                mact[k] = 0; mprev[k] = 0; movr[k] = 0; mpos[k] = 0;
            end else begin
                bit r;
                r = done_s[k] && !mprev[k];
                mprev[k] = done_s[k];
                if (mact[k] && rdy[k]) begin
                    if (mpos[k] == 63) mact[k] = 0;
                    else mpos[k]++;
                end
                if (r) begin
                    if (!mact[k]) begin
                        for (int i = 0; i < 8; i++)
                            for (int c = 0; c < 8; c++) begin
                                int j;
                                j = (k == 0 && (i % 2) == 1) ? 7 - c : c;
                                mframe[k][i*8+c] = '{elem_of(i, j), i, j, (i == 7 && c == 7)};
                            end
                        mpos[k] = 0;
                        mact[k] = 1;
                    end else begin
                        movr[k] = 1;
                    end
                end
            end
        end
    end

    // Record what the DUTs actually hand over (pre-edge output values).
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            if (rst && o_valid[k] && rdy[k]) begin
                if (log_n[k] < 256)
                    logv[k][log_n[k]] = '{o_data[k], int'(o_row[k]), int'(o_col[k]), o_last[k]};
                log_n[k]++;
            end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("valid%0d", k), o_valid[k], mact[k]);
            check($sformatf("busy%0d", k), o_busy[k], mact[k]);
            check($sformatf("overrun%0d", k), o_ovr[k], movr[k]);
            check($sformatf("last%0d", k), o_last[k], mact[k] ? mframe[k][mpos[k]].last : 1'b0);
            if (mact[k]) begin
                check($sformatf("data%0d", k), o_data[k], mframe[k][mpos[k]].data);
                check($sformatf("row%0d", k), o_row[k], mframe[k][mpos[k]].row);
                check($sformatf("col%0d", k), o_col[k], mframe[k][mpos[k]].col);
            end
        end
    end

    task automatic load_a();
        int a0 [8] = '{0, 12, 4, 9, 50, 3, 12, 19};
        int a1 [8] = '{12, 5, 9, 12, 18, 35, 9, 12};
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                values[elem_lsb(i, j) +: 8] = (i == 0) ? 8'(a0[j]) : (i == 1) ? 8'(a1[j]) : 8'((i * 8 + j) * 7);
    endtask

    task automatic load_fn(input int base, input int mul);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                values[elem_lsb(i, j) +: 8] = 8'(base + (i * 8 + j) * mul);
    endtask

    task automatic pulse(input int k);
        done_s[k] = 1'b1;
        @(negedge clk);
        done_s[k] = 1'b0;
    endtask

    task automatic wait_drain(input int k, input int bound, input bit toggle);
        int n = 0;
        while (mact[k] && n < bound) begin
            if (toggle) rdy[k] = (n % 4 == 0) || (n % 4 == 3);
            @(negedge clk);
            n++;
        end
        if (mact[k]) check($sformatf("drain_timeout%0d", k), 0, 1);
    endtask

    initial begin
        int lasts;
        int drop;
        int n;
        int exp16 [16] = '{0, 12, 4, 9, 50, 3, 12, 19, 12, 9, 35, 18, 12, 9, 5, 12};

        rst = 1'b0; done_s[0] = 0; done_s[1] = 0; rdy[0] = 0; rdy[1] = 0;
        values = '0; log_n[0] = 0; log_n[1] = 0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_valid%0d", k), o_valid[k], 0);
            check($sformatf("rst_busy%0d", k), o_busy[k], 0);
            check($sformatf("rst_last%0d", k), o_last[k], 0);
            check($sformatf("rst_ovr%0d", k), o_ovr[k], 0);
            check($sformatf("rst_data%0d", k), o_data[k], 0);
            check($sformatf("rst_row%0d", k), o_row[k], 0);
            check($sformatf("rst_col%0d", k), o_col[k], 0);
        end
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("idle_valid0", o_valid[0], 0);
            check("idle_valid1", o_valid[1], 0);
        end

        // Snake stream, ready held high.
        load_a(); rdy[0] = 1; log_n[0] = 0;
        pulse(0);
        wait_drain(0, 200, 0);
        check("snake_count", log_n[0], 64);
        for (int e = 0; e < 16; e++) check($sformatf("snake_e%0d", e), logv[0][e].data, exp16[e]);
        check("snake_col_e8", logv[0][8].col, 7);
        lasts = 0;
        for (int e = 0; e < 64; e++) lasts += logv[0][e].last;
        check("snake_last_cnt", lasts, 1);
        check("snake_last_pos", logv[0][63].last, 1);
        check("snake_last_row", logv[0][63].row, 7);
        check("snake_last_col", logv[0][63].col, 0);

        // Row-major with backpressure; values trashed one cycle after capture.
        load_a(); log_n[1] = 0;
        pulse(1);
        values = '1;
        wait_drain(1, 400, 1);
        rdy[1] = 0;
        check("rm_count", log_n[1], 64);
        check("rm_e9_data", logv[1][9].data, 5);
        check("rm_e9_col", logv[1][9].col, 1);
        check("rm_e63_row", logv[1][63].row, 7);
        check("rm_e63_col", logv[1][63].col, 7);

        // Back-to-back frames on the snake unit, then a mid-frame rise.
        load_fn(3, 7); rdy[0] = 1; log_n[0] = 0; drop = 0;
        pulse(0);
        n = 0;
        while (!(mact[0] && mpos[0] == 63) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("b2b_timeout", 0, 1);
        load_fn(100, 1);
        pulse(0);
        check("b2b_valid", o_valid[0], 1);
        check("b2b_row", o_row[0], 0);
        check("b2b_col", o_col[0], 0);
        check("b2b_data", o_data[0], 100);
        n = 0;
        while (!(mact[0] && mpos[0] == 20) && n < 200) begin
            if (!o_busy[0]) drop++;
            @(negedge clk); n++;
        end
        if (n >= 200) check("mid_timeout", 0, 1);
        values = '0;
        values[7:0] = 8'hAA;
        pulse(0);
        check("ovr_set", o_ovr[0], 1);
        while (mact[0] && n < 400) begin
            if (!o_busy[0]) drop++;
            @(negedge clk); n++;
        end
        check("b2b_busy_drop", drop, 0);
        check("b2b_count", log_n[0], 128);
        check("b2b_e8", logv[0][64+8].data, 115);
        check("b2b_e20", logv[0][64+20].data, 120);

        // Reset mid-frame on the row-major unit, released with done high.
        load_a(); rdy[1] = 1; log_n[1] = 0;
        pulse(1);
        n = 0;
        while (!(mact[1] && mpos[1] == 30) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("rstmid_timeout", 0, 1);
        rst = 1'b0;
        load_fn(100, 1);
        done_s[1] = 1;
        @(negedge clk);
        check("rstmid_valid", o_valid[1], 0);
        check("rstmid_ovr0", o_ovr[0], 0);
        rst = 1'b1;
        @(negedge clk);
        check("rel_valid", o_valid[1], 1);
        check("rel_row", o_row[1], 0);
        check("rel_col", o_col[1], 0);
        check("rel_data", o_data[1], 100);
        done_s[1] = 0;
        wait_drain(1, 200, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sort_unloader.md
# sort_unloader

Drains the flattened ROW×COL result matrix of the parallel sorter as a serial element stream. A rising edge on `done` snapshots the whole matrix bus into local storage, which frees the sorter to start its next frame. The block then emits one element per valid/ready handshake, in snake (boustrophedon) order or row-major order, and tags each element with its row and column. It sits between the sorter's matrix output and any downstream serial consumer.

## Interface
- `WIDTH`, 8, bits per element
- `ROW`, 8, matrix rows (≥2)
- `COL`, 8, matrix columns (≥2)
- `SNAKE`, 1, 1 = odd rows emitted in descending column order; 0 = row-major
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  reset; synchronous, active-low
- `done`  in  1  sorter-finished level; its rising edge triggers capture
- `values`  in  WIDTH*ROW*COL  flattened matrix; element (i,j) at bits [(i*COL+j+1)*WIDTH-1 : (i*COL+j)*WIDTH]
- `out_data`  out  WIDTH  current element
- `out_row`  out  $clog2(ROW)  row index of `out_data`
- `out_col`  out  $clog2(COL)  column index of `out_data`
- `out_valid`  out  1  element valid
- `out_last`  out  1  high with the final element of a frame
- `out_ready`  in  1  consumer accepts the element
- `busy`  out  1  frame in progress (STREAM state)
- `overrun`  out  1  sticky: a `done` edge was dropped; cleared only by reset

## Operation
- Reset (`rst`=0 at an edge): all outputs are 0, `done_q`=0, state IDLE, and the snapshot contents are don't-care. A reset during a frame aborts the frame with no further elements.
- Edge detect: `rise = done & ~done_q`, and `done_q <= done` every cycle. If `done` is already high when reset is released, this counts as a rising edge.
- IDLE: on `rise`, capture `values` into the snapshot, set row=0 and col=0, and go to STREAM. On entry to STREAM, `out_valid`=1 and `busy`=1.
- STREAM: a handshake is `out_valid & out_ready`. Each handshake advances the index.
  - SNAKE=0: col increments; when it wraps at COL-1, row increments.
  - SNAKE=1: even rows count col upward; odd rows count col downward. At the row end, col stays at the edge value (COL-1 or 0) and row increments.
- `out_data` = snapshot[row][col]. `out_last` = 1 exactly at the final element, which is row ROW-1 with col COL-1 (even final row or SNAKE=0) or col 0 (odd final row with SNAKE=1).
- Final handshake: the block returns to IDLE, with `out_valid`, `busy` and `out_last` at 0 the next cycle. The exception is a `rise` in the same cycle: the block recaptures and stays in STREAM with element (0,0) of the new frame. There is no bubble.
- A `rise` in STREAM in any cycle other than the final handshake is ignored and sets `overrun`. The snapshot stays unchanged.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_row`, `out_col` and `out_last` hold stable.

## Timing
- Capture latency: `rise` is sampled at edge n, and the first element is valid after edge n.
- Throughput is 1 element/cycle. With `out_ready` held high, a frame occupies exactly ROW*COL cycles of `out_valid`.
- Outputs are registered or decoded from registered state only. There is no combinational path from `out_ready` or `done` to any output.
- `values` is sampled only at the capture edge. It may change on any other cycle.

## Structure
- The package `sort_pkg` holds:
  - default WIDTH/ROW/COL constants shared with the sorter
  - the state enum {IDLE, STREAM}
  - the function `elem_lsb(i,j)` returning (i*COL+j)*WIDTH, used for both packing and unpacking
- Sub-module `snake_counter`: row/col index generator with `clr` and `adv` inputs and `row`, `col` and `last` outputs, parameterised by ROW, COL and SNAKE.
- The top level contains the snapshot register array, the edge detector, the FSM, the output mux and the overrun flag.

## Test plan
- Reset state: hold `rst`=0 for 2 cycles. All outputs read 0. Release with `done`=0: `out_valid` stays 0 for 10 cycles.
- Snake stream:
  - Setup: 8×8 matrix with row0 = 0,12,4,9,50,3,12,19 and row1 = 12,5,9,12,18,35,9,12 (cols 0..7), `out_ready`=1, `done` pulsed.
  - Expected: first 16 outputs are 0,12,4,9,50,3,12,19 then 12,9,35,18,12,9,5,12.
  - Expected: `out_col` of element 8 is 7, and `out_last` is high only on output 64, at (7,0).
- SNAKE=0 backpressure:
  - Stimulus: toggle `out_ready` as 1,0,0,1,…
  - Expected: every element appears exactly once in row-major order, with data stable while stalled.
  - Expected: 64 handshakes total.
- Back-to-back: a second `done` rise coincident with the final handshake gives the new frame's element (0,0) on the next cycle, with `busy` never dropping. A third rise at mid-frame element 20 sets `overrun`=1, and the current frame completes unchanged.
- Reset mid-frame: assert `rst` after 30 handshakes. `out_valid`=0 on the next cycle. Release with `done` held high: a new capture occurs and element (0,0) appears.
- Snapshot isolation: change `values` to all 0xFF one cycle after capture. The streamed data still matches the captured matrix.
